// File: rtl/bank_queue_ctrl.sv
// Queue occupancy tracker fed by active-low entry/exit photocells, with sticky
// overflow/underflow errors and a multi-cycle restoring divider for the expected wait.
module bank_queue_ctrl #(
  parameter int CNT_W       = 4,
  parameter int TELLER_W    = 2,
  parameter int SVC_TIME    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_W      = $clog2(SVC_TIME * ((2 ** CNT_W - 1) + (2 ** TELLER_W - 1) - 1) + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                phc_in_n,
  input  logic                phc_out_n,
  input  logic [TELLER_W-1:0] tcount,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    pcount,
  output logic                empty,
  output logic                full,
  output logic                ovf_err,
  output logic                unf_err,
  output logic [WAIT_W-1:0]   pwait,
  output logic                pwait_valid
);

  localparam int REM_W  = WAIT_W + 1;
  localparam int STEP_W = $clog2(WAIT_W + 1);

  localparam logic [CNT_W-1:0]  PMAX       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ONES  = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] SVC_W      = WAIT_W'(SVC_TIME);
  localparam logic [REM_W-1:0]  REM_ZERO   = {REM_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(WAIT_W - 1);
  localparam logic [TELLER_W-1:0] TEL_ZERO = {TELLER_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

  logic [SYNC_STAGES-1:0] sync_in_r;
  logic [SYNC_STAGES-1:0] sync_out_r;
  logic                   prev_in_r;
  logic                   prev_out_r;
  logic                   arrive_s;
  logic                   depart_s;

  logic [CNT_W-1:0]       pcount_r;
  logic [CNT_W-1:0]       pcount_nxt_s;
  logic                   empty_r;
  logic                   full_r;
  logic                   ovf_err_r;
  logic                   unf_err_r;
  logic                   ovf_set_s;
  logic                   unf_set_s;

  div_state_t             state_r;
  div_state_t             state_nxt_s;
  logic                   load_s;
  logic                   step_s;
  logic                   publish_s;
  logic                   opnd_chg_s;
  logic [CNT_W-1:0]       snap_p_r;
  logic [TELLER_W-1:0]    snap_t_r;
  logic [WAIT_W-1:0]      sum_s;
  logic [WAIT_W-1:0]      num_s;
  logic [WAIT_W-1:0]      quo_r;
  logic [REM_W-1:0]       rem_r;
  logic [REM_W-1:0]       div_r;
  logic [STEP_W-1:0]      step_r;
  logic                   zero_r;
  logic                   sat_r;
  logic [REM_W-1:0]       rem_sh_s;
  logic                   ge_s;
  logic [REM_W-1:0]       rem_nxt_s;
  logic [WAIT_W-1:0]      quo_nxt_s;
  logic [WAIT_W-1:0]      pwait_r;
  logic                   pwait_valid_r;

  // Photocell synchronisers plus previous-value flops for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_in_r  <= {SYNC_STAGES{1'b1}};
      sync_out_r <= {SYNC_STAGES{1'b1}};
      prev_in_r  <= 1'b1;
      prev_out_r <= 1'b1;
    end else begin
      sync_in_r  <= {sync_in_r[SYNC_STAGES-2:0], phc_in_n};
      sync_out_r <= {sync_out_r[SYNC_STAGES-2:0], phc_out_n};
      prev_in_r  <= sync_in_r[SYNC_STAGES-1];
      prev_out_r <= sync_out_r[SYNC_STAGES-1];
    end
  end

  assign arrive_s = prev_in_r & ~sync_in_r[SYNC_STAGES-1];
  assign depart_s = prev_out_r & ~sync_out_r[SYNC_STAGES-1];

  // Next occupancy and error triggers; simultaneous arrive and depart cancel out
  always_comb begin
    pcount_nxt_s = pcount_r;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    case ({arrive_s, depart_s})
      2'b10: begin
        if (!full_r) begin
          pcount_nxt_s = pcount_r + CNT_ONE;
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_r) begin
          pcount_nxt_s = pcount_r - CNT_ONE;
        end else begin
          unf_set_s = 1'b1;
        end
      end
      default: begin
        pcount_nxt_s = pcount_r;
      end
    endcase
  end

  // Occupancy, flags derived from the next count, and sticky errors (set beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      pcount_r  <= CNT_ZERO;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      pcount_r  <= pcount_nxt_s;
      empty_r   <= (pcount_nxt_s == CNT_ZERO);
      full_r    <= (pcount_nxt_s == PMAX);
      ovf_err_r <= ovf_set_s | (ovf_err_r & ~err_clr);
      unf_err_r <= unf_set_s | (unf_err_r & ~err_clr);
    end
  end

  // Numerator is only meaningful for pcount!=0; the zero case is overridden at publish
  assign opnd_chg_s = ({pcount_r, tcount} != {snap_p_r, snap_t_r});
  assign sum_s      = WAIT_W'(pcount_r) + WAIT_W'(tcount) - WAIT_ONE;
  assign num_s      = sum_s * SVC_W;

  assign rem_sh_s  = {rem_r[WAIT_W-1:0], quo_r[WAIT_W-1]};
  assign ge_s      = (rem_sh_s >= div_r);
  assign rem_nxt_s = ge_s ? (rem_sh_s - div_r) : rem_sh_s;
  assign quo_nxt_s = {quo_r[WAIT_W-2:0], ge_s};

  // Divider state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divider next state; any operand change restarts the division from scratch
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    publish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (opnd_chg_s) begin
          state_nxt_s = ST_DIV;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (opnd_chg_s) begin
          state_nxt_s = ST_DIV;
          load_s      = 1'b1;
        end else if (step_r == STEP_LAST) begin
          state_nxt_s = ST_DONE;
          step_s      = 1'b1;
        end else begin
          state_nxt_s = ST_DIV;
          step_s      = 1'b1;
        end
      end
      ST_DONE: begin
        if (opnd_chg_s) begin
          state_nxt_s = ST_DIV;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
          publish_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Divider datapath, operand snapshot and published result
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_p_r      <= CNT_ZERO;
      snap_t_r      <= TEL_ZERO;
      quo_r         <= WAIT_ZERO;
      rem_r         <= REM_ZERO;
      div_r         <= REM_ZERO;
      step_r        <= STEP_ZERO;
      zero_r        <= 1'b0;
      sat_r         <= 1'b0;
      pwait_r       <= WAIT_ZERO;
      pwait_valid_r <= 1'b1;
    end else if (load_s) begin
      snap_p_r      <= pcount_r;
      snap_t_r      <= tcount;
      quo_r         <= num_s;
      rem_r         <= REM_ZERO;
      div_r         <= REM_W'(tcount);
      step_r        <= STEP_ZERO;
      zero_r        <= (pcount_r == CNT_ZERO);
      sat_r         <= (tcount == TEL_ZERO);
      pwait_valid_r <= 1'b0;
    end else if (step_s) begin
      quo_r  <= quo_nxt_s;
      rem_r  <= rem_nxt_s;
      step_r <= step_r + STEP_ONE;
    end else if (publish_s) begin
      if (zero_r) begin
        pwait_r <= WAIT_ZERO;
      end else if (sat_r) begin
        pwait_r <= WAIT_ONES;
      end else begin
        pwait_r <= quo_r;
      end
      pwait_valid_r <= 1'b1;
    end else begin
      pwait_valid_r <= pwait_valid_r;
    end
  end

  assign pcount      = pcount_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign ovf_err     = ovf_err_r;
  assign unf_err     = unf_err_r;
  assign pwait       = pwait_r;
  assign pwait_valid = pwait_valid_r;

endmodule
